// File: rtl/key_pkg.sv
// Shared constants and types for the 10-key debouncer.
// Provides KEY_NUM, default timing parameters and the warm-up FSM state enum.
package key_pkg;

    localparam int          KEY_NUM      = 10;
    localparam logic [15:0] TICK_DIV_DEF = 16'd50000;
    localparam int          STABLE_N_DEF = 4;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } wu_state_e;

endpackage

// File: rtl/key_db_cell.sv
// Single-key debounce cell: two-flop synchronizer, tick-gated stability
// counter, debounced level and registered rising-edge pulse.
// Ports: clk, rst (sync, active-high), key_in (raw), tick (sample strobe),
//        pulse_en (allow press pulses), din (debounced), press_pulse.
module key_db_cell
    import key_pkg::*;
#(
    parameter int STABLE_N = STABLE_N_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    input  logic tick,
    input  logic pulse_en,
    output logic din,
    output logic press_pulse
);

    localparam logic [3:0] LAST = 4'(STABLE_N - 1);

    logic       s1_q, s2_q;
    logic       din_q, din_d;
    logic [3:0] cnt_q, cnt_d;
    logic       press_q, press_d;

    always_comb begin
        din_d   = din_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (s2_q == din_q) begin
                cnt_d = 4'd0;
            end else if (cnt_q == LAST) begin
                // Enough consecutive disagreeing samples: accept new level.
                din_d = ~din_q;
                cnt_d = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
        press_d = pulse_en & din_d & ~din_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            din_q   <= 1'b0;
            cnt_q   <= 4'd0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= key_in;
            s2_q    <= s1_q;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign din         = din_q;
    assign press_pulse = press_q;

endmodule

// File: rtl/key_debounce10.sv
// Ten-key debouncer feeding a 10-to-4 encoder: shared sample prescaler,
// warm-up FSM gating the encoder enable, and one key_db_cell per key.
// Ports: clk, rst (sync, active-high), key_in[9:0] raw keys,
//        din[9:0] debounced levels, en encoder enable,
//        press_pulse[9:0] press strobes, tick sample strobe.
module key_debounce10
    import key_pkg::*;
#(
    parameter logic [15:0] TICK_DIV = TICK_DIV_DEF,
    parameter int          STABLE_N = STABLE_N_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] din,
    output logic               en,
    output logic [KEY_NUM-1:0] press_pulse,
    output logic               tick
);

    localparam logic [15:0] PRE_LAST = TICK_DIV - 16'd1;
    localparam logic [3:0]  WU_LAST  = 4'(STABLE_N - 1);

    logic [15:0] pre_q, pre_d;
    logic        tick_q, tick_d;
    wu_state_e   state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        en_q, en_d;

    // tick is registered so it is high exactly while the count sits at
    // TICK_DIV-1; with TICK_DIV=1 that is every cycle out of reset.
    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? 16'd0 : pre_q + 16'd1;
        tick_d = (pre_d == PRE_LAST);
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (state_q == WARMUP && tick_q) begin
            if (wcnt_q == WU_LAST) begin
                state_d = RUN;
                wcnt_d  = 4'd0;
            end else begin
                wcnt_d = wcnt_q + 4'd1;
            end
        end
        en_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= 16'd0;
            tick_q  <= 1'b0;
            state_q <= WARMUP;
            wcnt_q  <= 4'd0;
            en_q    <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            en_q    <= en_d;
        end
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : gen_cell
        key_db_cell #(
            .STABLE_N(STABLE_N)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .key_in     (key_in[i]),
            .tick       (tick_q),
            .pulse_en   (en_q),
            .din        (din[i]),
            .press_pulse(press_pulse[i])
        );
    end

    assign tick = tick_q;
    assign en   = en_q;

endmodule

// File: tb/tb_key_debounce10.sv
// Directed self-checking bench for key_debounce10 (TICK_DIV=4, STABLE_N=3).
// Covers reset, warm-up, clean press, glitch, bounce, multi-key, mid reset.
module tb_key_debounce10;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] key_in;
    logic [9:0] din;
    logic       en;
    logic [9:0] press_pulse;
    logic       tick;

    int checks = 0;
    int errors = 0;
    int pulse_cnt [10];
    int k;
    int seen;

    key_debounce10 #(
        .TICK_DIV(16'd4),
        .STABLE_N(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .din        (din),
        .en         (en),
        .press_pulse(press_pulse),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++)
            if (press_pulse[i]) pulse_cnt[i]++;
    endtask

    task automatic steps(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic clr_pulses();
        for (int i = 0; i < 10; i++) pulse_cnt[i] = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clr_pulses();
        rst    = 1'b1;
        key_in = 10'h000;

        // Reset, then warm-up: ticks after 3, 7, 11 edges; en after 12.
        steps(2);
        check("rst_din", 32'(din), 32'h0);
        check("rst_en", 32'(en), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_pulse", 32'(press_pulse), 32'h0);
        rst = 1'b0;
        steps(3);
        check("wu_tick1", 32'(tick), 32'h1);
        check("wu_en1", 32'(en), 32'h0);
        steps(4);
        check("wu_tick2", 32'(tick), 32'h1);
        check("wu_en2", 32'(en), 32'h0);
        steps(4);
        check("wu_tick3", 32'(tick), 32'h1);
        check("wu_en3", 32'(en), 32'h0);
        step();
        check("wu_run_en", 32'(en), 32'h1);
        check("wu_din", 32'(din), 32'h0);

        // Clean press on key 3.
        clr_pulses();
        key_in[3] = 1'b1;
        k = 0;
        while (din[3] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        checks++;
        assert (k >= 10 && k <= 14) else begin
            errors++;
            $error("FAIL press_latency: observed %0d expected 10..14", k);
        end
        check("press_din", 32'(din), 32'h008);
        check("press_pulse_hi", 32'(press_pulse), 32'h008);
        step();
        check("press_pulse_lo", 32'(press_pulse), 32'h0);
        steps(30 - k - 1);
        check("press_pulse_cnt", 32'(pulse_cnt[3]), 32'd1);
        key_in[3] = 1'b0;
        steps(20);
        check("release3_din", 32'(din), 32'h0);
        check("release3_pulses", 32'(pulse_cnt[3]), 32'd1);

        // Glitch on key 5: 5 cycles high cannot reach 3 stable ticks.
        clr_pulses();
        key_in[5] = 1'b1;
        steps(5);
        key_in[5] = 1'b0;
        steps(20);
        check("glitch_din", 32'(din), 32'h0);
        check("glitch_pulse", 32'(pulse_cnt[5]), 32'd0);

        // Bounce on key 0: 8 segments of 3 cycles, then hold high.
        clr_pulses();
        seen = 0;
        for (int s = 0; s < 8; s++) begin
            key_in[0] = (s % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                step();
                if (din[0]) seen++;
            end
        end
        check("bounce_din_stay0", 32'(seen), 32'd0);
        check("bounce_no_pulse", 32'(pulse_cnt[0]), 32'd0);
        key_in[0] = 1'b1;
        k = 0;
        while (din[0] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        checks++;
        assert (k >= 10 && k <= 14) else begin
            errors++;
            $error("FAIL bounce_latency: observed %0d expected 10..14", k);
        end
        steps(20);
        check("bounce_din", 32'(din), 32'h001);
        check("bounce_one_pulse", 32'(pulse_cnt[0]), 32'd1);
        key_in[0] = 1'b0;
        steps(20);
        check("bounce_release", 32'(din), 32'h0);

        // Keys 9 and 2 together, then release together.
        clr_pulses();
        key_in[9] = 1'b1;
        key_in[2] = 1'b1;
        k = 0;
        while (din === 10'h000 && k < 20) begin
            step();
            k++;
        end
        check("multi_din", 32'(din), 32'h204);
        check("multi_pulse", 32'(press_pulse), 32'h204);
        steps(10);
        key_in[9] = 1'b0;
        key_in[2] = 1'b0;
        k = 0;
        while (din === 10'h204 && k < 20) begin
            step();
            k++;
        end
        check("multi_release", 32'(din), 32'h0);
        steps(5);
        check("multi_pulse9", 32'(pulse_cnt[9]), 32'd1);
        check("multi_pulse2", 32'(pulse_cnt[2]), 32'd1);

        // Mid-operation reset with key 7 held.
        key_in[7] = 1'b1;
        k = 0;
        while (din[7] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("mid_pre_din", 32'(din), 32'h080);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_din", 32'(din), 32'h0);
        check("mid_rst_en", 32'(en), 32'h0);
        check("mid_rst_cnt", 32'(dut.gen_cell[7].u_cell.cnt_q), 32'h0);
        k = 0;
        while (din[7] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        checks++;
        assert (k >= 10 && k <= 14) else begin
            errors++;
            $error("FAIL mid_latency: observed %0d expected 10..14", k);
        end
        check("mid_en_run", 32'(en), 32'h1);
        check("mid_din", 32'(din), 32'h080);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce10.md
KEY_DEBOUNCE10 -- requirements
Module: key_debounce10

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16'd50000, meaning clock cycles per sample tick (legal range 1..65535).
REQ-002 SHALL have parameter STABLE_N, default 4, meaning consecutive disagreeing samples required to change a debounced level (legal range 1..15).
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port key_in  input  10  raw asynchronous key levels, active-high, bit i = key i.
REQ-006 SHALL have port din  output  10  debounced key levels, driving the downstream 10-to-4 encoder data input.
REQ-007 SHALL have port en  output  1  encoder enable; low during warm-up, high in RUN.
REQ-008 SHALL have port press_pulse  output  10  one-cycle pulse per key on a debounced 0->1 transition.
REQ-009 SHALL have port tick  output  1  sample-tick strobe, exported for the bench.
REQ-010 SHALL use one clock only; reset is synchronous and active-high.

Function
REQ-011 SHALL pass each key_in bit through a two-flop synchronizer, giving sync[i] two cycles after key_in[i].
REQ-012 SHALL run a prescaler counting 0..TICK_DIV-1 and wrapping to 0, asserting tick for exactly one cycle when the count equals TICK_DIV-1.
REQ-013 SHALL, with TICK_DIV=1, assert tick on every cycle.
REQ-014 SHALL keep a per-key counter cnt[i] of 4 bits that is evaluated only on tick cycles.
REQ-015 SHALL, on tick when sync[i]==din[i], clear cnt[i].
REQ-016 SHALL, on tick when sync[i]!=din[i] and cnt[i]<STABLE_N-1, increment cnt[i].
REQ-017 SHALL, on tick when sync[i]!=din[i] and cnt[i]==STABLE_N-1, toggle din[i] and clear cnt[i] in the same edge.
REQ-018 SHALL leave din and cnt unchanged on non-tick cycles.
REQ-019 SHALL register press_pulse[i] so that it is high for exactly the one cycle in which din[i] is first 1 after being 0; release (1->0) produces no pulse.
REQ-020 SHALL treat the 10 keys independently; simultaneous changes on several keys update in the same cycle, and din may carry multiple 1s (priority resolution belongs downstream).
REQ-021 SHALL never change din[i] in response to a pulse that is shorter than STABLE_N consecutive ticks.
REQ-022 SHALL update din[i] between 2+(STABLE_N-1)*TICK_DIV+1 and 2+STABLE_N*TICK_DIV cycles after a clean key_in edge, counted inclusive.
REQ-023 SHALL implement a warm-up FSM with two states, WARMUP and RUN: reset enters WARMUP; after STABLE_N ticks it moves to RUN; RUN is held until the next reset.
REQ-024 SHALL drive en=0 in WARMUP and en=1 in RUN, registered, and SHALL suppress press_pulse in WARMUP while still updating din.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set din=0, press_pulse=0, en=0, tick=0, prescaler=0, all cnt=0, synchronizer flops=0, FSM=WARMUP.
REQ-026 SHALL let rst override all other activity, including a tick or a toggle due in the same cycle.
REQ-027 SHALL restart the warm-up count from zero after a reset asserted mid-operation.

Structure
REQ-028 SHALL place KEY_NUM=10, the default TICK_DIV and STABLE_N, and the FSM state enum {WARMUP, RUN} in shared package key_pkg.
REQ-029 SHALL implement per-key synchronizer, counter, debounced level and edge detection in sub-module key_db_cell, instantiated KEY_NUM times in a generate loop.
REQ-030 SHALL keep the prescaler and warm-up FSM in key_debounce10 and broadcast tick to every cell.

Verification (TICK_DIV=4, STABLE_N=3)
REQ-031 SHALL check reset and warm-up: apply rst for 2 cycles, key_in=0 -> din=0, en=0 through ticks 1-2, en=1 the cycle after tick 3.
REQ-032 SHALL check a clean press: key_in[3]=1 held 30 cycles in RUN -> din[3]=1 within 10..14 cycles, press_pulse[3] high exactly 1 cycle, din=10'h008.
REQ-033 SHALL check glitch rejection: key_in[5]=1 for 5 cycles, then 0 -> din[5] stays 0, no press_pulse[5].
REQ-034 SHALL check bounce: key_in[0] toggling every 3 cycles for 24 cycles, then held 1 -> din[0] rises only after the hold phase, with a single press_pulse[0].
REQ-035 SHALL check simultaneous keys and release: key_in[9] and key_in[2] both rise together -> din=10'h204 in one cycle with two pulses; on release din returns to 0 with no pulses.
REQ-036 SHALL check mid-operation reset: with din[7]=1, assert rst 1 cycle -> next cycle din=0, en=0, cnt=0; din[7] re-rises 10..14 cycles later with en back in RUN.
